// File: rtl/huffman_pack.sv
// Huffman encoder / bit packer: looks up each symbol in a runtime-loaded code table and
// concatenates the codes MSB-first into W-bit output words, with zero-padded flush.
module huffman_pack #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_in,
    input  logic         en_in,
    output logic         d_req,
    input  logic         ready_in,
    input  logic [W-1:0] d_conf,
    input  logic [W-1:0] h_conf,
    input  logic [W-1:0] w_conf,
    input  logic         en_conf,
    input  logic         new_conf,
    input  logic         flush,
    output logic [W-1:0] d_out,
    output logic         en_out,
    output logic         err,
    output logic         flush_done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(2 * W) + 1;
    localparam logic [W-1:0]  C_WMAX  = W[W-1:0];
    localparam logic [CW-1:0] C_WCNT  = W[CW-1:0];
    localparam logic [PW-1:0] C_DEPTH = DEPTH[PW-1:0];

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [W-1:0]    r_tab_d [DEPTH];
    logic [W-1:0]    r_tab_h [DEPTH];
    logic [W-1:0]    r_tab_w [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]   r_wr_ptr;

    logic [2*W-1:0]  r_acc;
    logic [CW-1:0]   r_cnt;
    logic [2*W-1:0]  w_acc_next;
    logic [CW-1:0]   w_cnt_next;

    logic [DEPTH-1:0] w_match;
    logic            w_hit;
    logic [W-1:0]    w_code;
    logic [W-1:0]    w_len;
    logic [W-1:0]    w_code_mask;
    logic [2*W-1:0]  w_code_al;
    logic            w_cfg_bad;
    logic            w_cfg_ok;
    logic            w_cfg_rej;
    logic            w_accept;
    logic            w_push;
    logic            w_miss;
    logic            w_pop;
    logic            w_pad;
    logic            w_done;

    // ---------------- code table ----------------
    assign w_cfg_bad = (w_conf == '0) || (w_conf > C_WMAX) || (r_wr_ptr >= C_DEPTH);
    assign w_cfg_ok  = en_conf && !new_conf && !w_cfg_bad;
    assign w_cfg_rej = en_conf && !new_conf && w_cfg_bad;

    always_ff @(posedge clk) begin
        if (w_cfg_ok) begin
            r_tab_d[r_wr_ptr[AW-1:0]] <= d_conf;
            r_tab_h[r_wr_ptr[AW-1:0]] <= h_conf;
            r_tab_w[r_wr_ptr[AW-1:0]] <= w_conf;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
        end else if (new_conf) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
        end else if (w_cfg_ok) begin
            r_valid[r_wr_ptr[AW-1:0]] <= 1'b1;
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_match[gi] = r_valid[gi] && (r_tab_d[gi] == d_in);
        end
    endgenerate

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        w_hit  = 1'b0;
        w_code = '0;
        w_len  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit  = 1'b1;
                w_code = r_tab_h[i];
                w_len  = r_tab_w[i];
            end
        end
    end

    // ---------------- bit buffer ----------------
    assign w_code_mask = w_code & ~({W{1'b1}} << w_len);
    assign w_code_al   = ({w_code_mask, {W{1'b0}}} << (C_WMAX - w_len)) >> r_cnt;

    assign d_req    = (r_state == S_RUN) && (r_cnt < C_WCNT) && !new_conf;
    assign w_accept = en_in && d_req;
    assign w_push   = w_accept && w_hit;
    assign w_miss   = w_accept && !w_hit;
    assign w_pop    = (r_cnt >= C_WCNT) && ready_in && !new_conf;
    assign w_pad    = (r_state == S_FLUSH) && (r_cnt != '0) && (r_cnt < C_WCNT)
                      && ready_in && !new_conf;
    assign w_done   = (r_state == S_FLUSH) && (r_cnt == '0);

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_RUN:   if (flush)  w_state_next = S_FLUSH;
            S_FLUSH: if (w_done) w_state_next = S_RUN;
            default: w_state_next = S_RUN;
        endcase
        // Bits below cnt are always zero, so a padded word needs no extra masking.
        if (new_conf) begin
            w_acc_next = '0;
            w_cnt_next = '0;
        end else if (w_pop) begin
            w_acc_next = r_acc << W;
            w_cnt_next = r_cnt - C_WCNT;
        end else if (w_pad) begin
            w_acc_next = '0;
            w_cnt_next = '0;
        end else if (w_push) begin
            w_acc_next = r_acc | w_code_al;
            w_cnt_next = r_cnt + CW'(w_len);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_RUN;
            r_acc      <= '0;
            r_cnt      <= '0;
            d_out      <= '0;
            en_out     <= 1'b0;
            err        <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_acc      <= w_acc_next;
            r_cnt      <= w_cnt_next;
            en_out     <= w_pop || w_pad;
            err        <= w_miss || w_cfg_rej;
            flush_done <= w_done;
            if (w_pop || w_pad) begin
                d_out <= r_acc[2*W-1 -: W];
            end
        end
    end

endmodule

// File: tb/tb_huffman_pack.sv
// Self-checking bench for huffman_pack: a bit-string model pushes expected words to a
// scoreboard queue; a monitor pops and compares every emitted word.
module tb_huffman_pack;

    localparam int W     = 8;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] d_in = '0;
    logic         en_in = 1'b0;
    logic         d_req;
    logic         ready_in = 1'b1;
    logic [W-1:0] d_conf = '0;
    logic [W-1:0] h_conf = '0;
    logic [W-1:0] w_conf = '0;
    logic         en_conf = 1'b0;
    logic         new_conf = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] d_out;
    logic         en_out;
    logic         err;
    logic         flush_done;

    always #5 clk = ~clk;

    huffman_pack #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .d_in       (d_in),
        .en_in      (en_in),
        .d_req      (d_req),
        .ready_in   (ready_in),
        .d_conf     (d_conf),
        .h_conf     (h_conf),
        .w_conf     (w_conf),
        .en_conf    (en_conf),
        .new_conf   (new_conf),
        .flush      (flush),
        .d_out      (d_out),
        .en_out     (en_out),
        .err        (err),
        .flush_done (flush_done)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] exp_q [$];
    int words_seen = 0;
    int err_seen   = 0;
    int fd_seen    = 0;
    int m_err      = 0;
    int m_fd       = 0;
    int m_words    = 0;

    logic [7:0] t_sym  [$];
    logic [7:0] t_code [$];
    logic [7:0] t_w    [$];
    int          m_cnt = 0;
    logic [31:0] m_acc = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (en_out) begin
            words_seen++;
            if (exp_q.size() == 0) begin
                chk("spurious_word", {31'b0, en_out}, 32'd0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("word", {24'b0, d_out}, {24'b0, e});
                $display("word %0d: d_out=0x%02h expected=0x%02h", words_seen, d_out, e);
            end
        end
        if (err)        err_seen++;
        if (flush_done) fd_seen++;
    end

    function automatic int lookup(input logic [7:0] s);
        for (int i = 0; i < t_sym.size(); i++)
            if (t_sym[i] == s) return i;
        return -1;
    endfunction

    task automatic m_push(input logic [7:0] s);
        int idx;
        idx = lookup(s);
        if (idx < 0) begin
            m_err++;
        end else begin
            m_acc = (m_acc << t_w[idx]) | (32'(t_code[idx]) & ((32'd1 << t_w[idx]) - 1));
            m_cnt += int'(t_w[idx]);
            if (m_cnt >= 8) begin
                exp_q.push_back(8'((m_acc >> (m_cnt - 8)) & 32'hff));
                m_words++;
                m_cnt -= 8;
                m_acc &= (32'd1 << m_cnt) - 1;
            end
        end
    endtask

    task automatic m_clear_all();
        t_sym.delete(); t_code.delete(); t_w.delete();
        m_cnt = 0;
        m_acc = '0;
    endtask

    task automatic cfg(input logic [7:0] d, input logic [7:0] h, input logic [7:0] w);
        @(negedge clk);
        d_conf = d; h_conf = h; w_conf = w; en_conf = 1'b1;
        @(negedge clk);
        en_conf = 1'b0;
        if (w == 0 || w > 8 || t_sym.size() >= DEPTH) m_err++;
        else begin
            t_sym.push_back(d); t_code.push_back(h); t_w.push_back(w);
        end
    endtask

    task automatic send(input logic [7:0] s);
        int t;
        @(negedge clk);
        d_in = s; en_in = 1'b1; t = 0;
        while (!d_req && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("d_req_timeout", {31'b0, d_req}, 32'd1);
        @(posedge clk);
        #1 en_in = 1'b0;
        m_push(s);
    endtask

    task automatic do_flush();
        int t;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (m_cnt > 0) begin
            exp_q.push_back(8'((m_acc << (8 - m_cnt)) & 32'hff));
            m_words++;
        end
        m_cnt = 0; m_acc = '0; m_fd++;
        t = 0;
        while (fd_seen < m_fd && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("flush_done", fd_seen, m_fd);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        repeat (3) @(negedge clk);
        chk("rst_d_out",      {24'b0, d_out},      32'd0);
        chk("rst_en_out",     {31'b0, en_out},     32'd0);
        chk("rst_err",        {31'b0, err},        32'd0);
        chk("rst_flush_done", {31'b0, flush_done}, 32'd0);
        chk("rst_d_req",      {31'b0, d_req},      32'd1);
        rst = 1'b1;

        cfg(8'h20, 8'b00,   8'd2);
        cfg(8'h21, 8'b01,   8'd2);
        cfg(8'h30, 8'b100,  8'd3);
        cfg(8'h31, 8'b101,  8'd3);
        cfg(8'h40, 8'b1100, 8'd4);

        // four 2-bit codes -> 0x11
        send(8'h20); send(8'h21); send(8'h20); send(8'h21);
        settle();
        chk("t1_words", words_seen, m_words);

        // 30,31 x4 -> 0x96 0x59 0x65
        for (int i = 0; i < 4; i++) begin
            send(8'h30); send(8'h31);
        end
        settle();
        chk("t2_words", words_seen, m_words);

        // partial word flush, then flush with empty buffer
        send(8'h40);
        do_flush();
        do_flush();
        settle();
        chk("t3_words", words_seen, m_words);

        // miss in the middle of a word leaves the bit count untouched
        send(8'h20); send(8'h99); send(8'h21); send(8'h20); send(8'h21);
        settle();
        chk("t4_err", err_seen, m_err);
        chk("t4_words", words_seen, m_words);

        // backpressure
        ready_in = 1'b0;
        w0 = words_seen;
        send(8'h20); send(8'h21); send(8'h20); send(8'h21);
        repeat (4) @(negedge clk);
        chk("bp_d_req", {31'b0, d_req}, 32'd0);
        chk("bp_hold",  words_seen, w0);
        ready_in = 1'b1;
        settle();
        chk("bp_release", words_seen, w0 + 1);

        // reset with 5 bits buffered: nothing emitted, table emptied
        send(8'h30); send(8'h20);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_d_out",  {24'b0, d_out},  32'd0);
        chk("midrst_en_out", {31'b0, en_out}, 32'd0);
        m_clear_all();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send(8'h20);
        settle();
        chk("empty_table_err", err_seen, m_err);

        @(negedge clk);
        new_conf = 1'b1;
        @(negedge clk);
        new_conf = 1'b0;
        m_clear_all();

        cfg(8'h20, 8'b00,   8'd2);
        cfg(8'h21, 8'b01,   8'd2);
        cfg(8'h30, 8'b100,  8'd3);
        cfg(8'h31, 8'b101,  8'd3);
        cfg(8'h40, 8'b1100, 8'd4);
        cfg(8'h50, 8'b011,  8'd0);
        cfg(8'h51, 8'b1,    8'd9);
        settle();
        chk("cfg_reject_err", err_seen, m_err);

        // fill the table (one duplicate of 0x20) then overflow it
        cfg(8'h20, 8'b11, 8'd2);
        for (int i = 1; i <= 10; i++) cfg(8'h60 + 8'(i), 8'b1, 8'd1);
        cfg(8'h70, 8'b1, 8'd1);
        settle();
        chk("cfg_full_err", err_seen, m_err);

        send(8'h20); send(8'h20); send(8'h20); send(8'h20);
        for (int i = 0; i < 8; i++) send(8'h6a);
        send(8'h40);
        do_flush();
        settle();

        chk("final_words", words_seen, m_words);
        chk("final_err",   err_seen,   m_err);
        chk("final_fd",    fd_seen,    m_fd);
        chk("queue_left",  exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
